// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, requests words from imem and hands them to decode.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
//
// state | meaning
// IDLE  | one cycle after reset, no request
// FETCH | imem request outstanding at pc
// HOLD  | instruction presented to decode, waiting for instr_ready
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_out,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic        fetch_timeout
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam logic [7:0] L_MAX_WAIT = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_cnt_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic [5:0]  r_opcode;
  logic [5:0]  w_opcode_nxt;
  logic [31:0] r_pc_out;
  logic [31:0] w_pc_out_nxt;
  logic        r_instr_valid;
  logic        w_instr_valid_nxt;
  logic        r_timeout;
  logic        w_timeout_nxt;

  logic        w_handshake;
  logic [31:0] w_p4;
  logic [31:0] w_br_off;
  logic [31:0] w_next_pc;

  assign w_handshake = (r_state == ST_HOLD) && r_instr_valid && instr_ready;

  // Redirect target is relative to the instruction being consumed, not to r_pc.
  assign w_p4     = r_pc_out + 32'd4;
  assign w_br_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  always_comb begin
    w_next_pc = w_p4;
    if (jump) begin
      w_next_pc = {w_p4[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      w_next_pc = w_p4 + w_br_off;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_instr_nxt       = r_instr;
    w_opcode_nxt      = r_opcode;
    w_pc_out_nxt      = r_pc_out;
    w_instr_valid_nxt = r_instr_valid;
    w_timeout_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        if (imem_valid) begin
          w_instr_nxt       = imem_rdata;
          w_opcode_nxt      = imem_rdata[31:26];
          w_pc_out_nxt      = r_pc;
          w_instr_valid_nxt = 1'b1;
          w_wait_cnt_nxt    = 8'd0;
          w_state_nxt       = ST_HOLD;
        end else if (r_wait_cnt == L_MAX_WAIT) begin
          // Address stays put, so staying in FETCH re-issues the same request.
          w_timeout_nxt  = 1'b1;
          w_wait_cnt_nxt = 8'd0;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 8'd1;
        end
      end

      ST_HOLD: begin
        if (w_handshake) begin
          w_instr_valid_nxt = 1'b0;
          w_pc_nxt          = w_next_pc;
          w_state_nxt       = ST_FETCH;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_wait_cnt    <= 8'd0;
      r_instr       <= 32'd0;
      r_opcode      <= 6'd0;
      r_pc_out      <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_instr       <= w_instr_nxt;
      r_opcode      <= w_opcode_nxt;
      r_pc_out      <= w_pc_out_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_timeout     <= w_timeout_nxt;
    end
  end

  assign imem_req      = (r_state == ST_FETCH);
  assign imem_addr     = r_pc;
  assign instr_valid   = r_instr_valid;
  assign instr         = r_instr;
  assign opcode        = r_opcode;
  assign pc_out        = r_pc_out;
  assign fetch_timeout = r_timeout;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_count <= 32'd0;
      r_stall_count <= 32'd0;
    end else begin
      if (w_handshake) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if ((r_state == ST_HOLD) && !instr_ready) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

endmodule
